// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + d.
// Start/busy/done handshake; any digit above 9 sets err and forces bin to zero.
module bcd2bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   sreg_q, sreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               busy_d, done_d, err_d;
  logic [BIN_W-1:0]   bin_d;

  logic [3:0]         digit_c;
  logic [BIN_W-1:0]   mac_c;
  logic               err_fin_c;
  logic               last_c;

  // Current digit and the multiply-accumulate step it feeds
  always_comb begin
    digit_c   = sreg_q[BCD_W-1 -: 4];
    mac_c     = (acc_q * BIN_W'(10)) + BIN_W'(digit_c);
    err_fin_c = sticky_q | (digit_c > 4'd9);
    last_c    = (cnt_q == CNT_W'(DIGITS - 1));
  end

  // State and datapath register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin      <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      busy     <= busy_d;
      done     <= done_d;
      bin      <= bin_d;
      err      <= err_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    busy_d   = busy;
    done_d   = 1'b0;
    bin_d    = bin;
    err_d    = err;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sreg_d   = bcd;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        acc_d    = mac_c;
        sreg_d   = sreg_q << 4;
        sticky_d = err_fin_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          bin_d   = err_fin_c ? '0 : mac_c;
          err_d   = err_fin_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: latency, error flag, busy-ignore, back-to-back and async reset.
module tb_bcd2bin_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    bin;
  logic                err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one conversion at a falling edge and check latency, result and the one-cycle done
  task automatic run_conv(input string tag, input logic [11:0] val,
                          input int exp_bin, input logic exp_err);
    int n;
    bcd   = val;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(DIGITS));
    check({tag, "_bin"}, 32'(bin), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_bin_hold"}, 32'(bin), 32'(exp_bin));
  endtask

  initial begin
    int n;
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv("zero", 12'h000, 0,   1'b0);
    run_conv("c999", 12'h999, 999, 1'b0);

    // Start re-pulsed and bcd changed mid-conversion must be ignored
    bcd   = 12'h427;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bcd   = 12'h111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("c427_done", 32'(done), 32'd1);
    check("c427_bin",  32'(bin),  32'd427);
    check("c427_err",  32'(err),  32'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("c427_single_done", 32'(dones), 32'd0);
    check("c427_idle", 32'(busy), 32'd0);

    run_conv("c1a3", 12'h1A3, 0,  1'b1);
    run_conv("c058", 12'h058, 58, 1'b0);

    // Start held high: a new conversion every DIGITS+1 clocks
    bcd   = 12'h250;
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("b2b_done_%0d", k), 32'(done), 32'((k % 4) == 3));
      if ((k % 4) == 3) check($sformatf("b2b_bin_%0d", k), 32'(bin), 32'd250);
    end
    start = 1'b0;
    @(negedge clk);

    // Reset asserted mid-conversion clears outputs at once, with no later done
    bcd   = 12'h731;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bin",  32'(bin),  32'd0);
    check("arst_err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy === 1'b1) n++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    check("arst_no_busy", 32'(n), 32'd0);
    check("arst_bin_hold", 32'(bin), 32'd0);

    run_conv("c731", 12'h731, 731, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the reverse path of the team's binary-to-BCD display logic.
- Takes a packed multi-digit BCD value, for example from switch inputs or a keypad digit buffer, and produces its unsigned binary value.
- Uses iterative multiply-by-10 accumulation, most significant digit first, one digit per clock.
- Uses a start/busy/done handshake and flags any non-decimal digit.

Parameters:
- DIGITS, 3, number of BCD digits converted (≥1).
- BIN_W, 10, binary output width. Must satisfy 2^BIN_W > 10^DIGITS − 1.

Ports:
- Clock, input, 1, system clock; all state changes on the rising edge.
- Resetn, input, 1, asynchronous active-low reset.
- Start, input, 1, conversion request; sampled only in IDLE.
- BCD, input, 4*DIGITS, packed BCD. BCD[4*DIGITS-1 -: 4] is the most significant digit; BCD[3:0] is the least significant digit.
- Busy, output, 1, high while a conversion is in progress.
- Done, output, 1, one-cycle pulse marking the cycle in which Bin and Err are updated.
- Bin, output, BIN_W, binary result; held until the next completion.
- Err, output, 1, set when any input digit is greater than 9; held with Bin.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - State goes to IDLE.
  - Busy=0, Done=0, Err=0, Bin=0.
  - Internal shift register, accumulator, digit counter and error flag are cleared.
  - Reset applied mid-conversion aborts the conversion. No Done is produced.
- States: IDLE, CONV.
- IDLE:
  - Busy=0.
  - If Start=1 at a rising edge:
    - Capture BCD into the shift register.
    - Clear accumulator, counter and sticky error.
    - Go to CONV; Busy becomes 1 after this edge.
  - If Start=0, remain in IDLE.
- CONV, per edge:
  - d = top 4 bits of the shift register.
  - acc <= acc*10 + d. Compute with BIN_W-bit arithmetic; truncation cannot occur under the parameter constraint.
  - Shift register shifts left by 4 bits.
  - sticky_err <= sticky_err | (d > 9).
  - counter increments.
- Conversion end: on the edge where counter == DIGITS−1 (the last digit):
  - Bin <= (final error ? 0 : acc*10+d).
  - Err <= final error, where final error = sticky_err | (d>9).
  - Done <= 1 for exactly one cycle.
  - State returns to IDLE; Busy becomes 0 after this edge.
- Latency: Start is accepted at edge E0. Done is high in the cycle following edge E0+DIGITS. For DIGITS=3, that is 3 clocks after acceptance.
- Start while Busy=1 is ignored. The BCD input is not re-sampled during CONV, so changing BCD mid-conversion has no effect.
- Done and Start may be coincident: state is IDLE in the Done cycle, so a Start then is accepted. This gives back-to-back conversions every DIGITS+1 clocks.
- Done is low in every cycle other than the completion cycle.
- Bin and Err change only at completion or reset.
- Err=1 always forces Bin=0.

Test Plan:
- Reset, then BCD=12'h000 with a Start pulse → Busy high for 3 cycles; Done pulse; Bin=0; Err=0.
- BCD=12'h999, Start → Done exactly 3 clocks after acceptance; Bin=999 (10'h3E7); Err=0.
- BCD=12'h427, Start, then BCD changed to 12'h111 and Start re-pulsed while Busy → single Done; Bin=427; Err=0; second Start ignored.
- BCD=12'h1A3, Start → Done; Err=1; Bin=0. A following conversion of 12'h058 → Err=0, Bin=58.
- Start held high continuously with BCD=12'h250 → Done every 4 clocks; Bin=250 each time.
- BCD=12'h731, Start, then Resetn low on the 2nd conversion clock → Busy, Done, Bin and Err all 0 immediately and asynchronously. After release, no Done appears until a new Start.
